// File: rtl/true_dual_port_ram_if.sv
// Bundle of the two RAM ports plus the collision flag.
// master drives the requests and samples the results. slave is the RAM itself.
interface true_dual_port_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  a_cs;
    logic                  a_we;
    logic                  a_oe;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_data_in;
    logic [DATA_WIDTH-1:0] a_data_out;
    logic                  a_rd_valid;

    logic                  b_cs;
    logic                  b_we;
    logic                  b_oe;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_data_in;
    logic [DATA_WIDTH-1:0] b_data_out;
    logic                  b_rd_valid;

    logic                  collision;

    modport master (
        output a_cs, a_we, a_oe, a_addr, a_data_in,
        output b_cs, b_we, b_oe, b_addr, b_data_in,
        input  a_data_out, a_rd_valid, b_data_out, b_rd_valid, collision
    );

    modport slave (
        input  a_cs, a_we, a_oe, a_addr, a_data_in,
        input  b_cs, b_we, b_oe, b_addr, b_data_in,
        output a_data_out, a_rd_valid, b_data_out, b_rd_valid, collision
    );
endinterface

// File: rtl/true_dual_port_ram.sv
// True dual-port RAM with one clock, two independent read/write ports,
// and a read latency of 1 or 2 cycles.
// Optional feature macro: TDPR_WRITE_THROUGH_EN. When it is defined, a read
// on one port returns the data that the other port writes to the same
// address in the same cycle. When it is not defined, such a read returns the
// old word (read-first).
//
// Valid semantics: there is no backpressure. A read is issued on an edge
// where cs=1, we=0 and oe=1. Its word appears on data_out with rd_valid=1
// for exactly one cycle, RD_LATENCY-1 edges later. Whenever rd_valid=0,
// data_out holds 0.
module true_dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 1
) (
    input logic                  clk,
    input logic                  rst,
    true_dual_port_ram_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("true_dual_port_ram: RD_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  a_wr;
    logic                  a_rd;
    logic                  b_wr;
    logic                  b_rd;
    logic                  b_wr_eff;
    logic                  same_addr;
    logic                  collision_d;
    logic [DATA_WIDTH-1:0] a_word;
    logic [DATA_WIDTH-1:0] b_word;

    // First pipeline stage. This is the only stage when RD_LATENCY is 1.
    logic                  a_v1;
    logic                  b_v1;
    logic [DATA_WIDTH-1:0] a_d1;
    logic [DATA_WIDTH-1:0] b_d1;
    logic                  collision_q;

    assign a_wr      = bus.a_cs & bus.a_we;
    assign a_rd      = bus.a_cs & ~bus.a_we & bus.a_oe;
    assign b_wr      = bus.b_cs & bus.b_we;
    assign b_rd      = bus.b_cs & ~bus.b_we & bus.b_oe;
    assign same_addr = (bus.a_addr == bus.b_addr);

    // If both ports write the same word, port A wins and the port B write is dropped.
    assign b_wr_eff  = b_wr & ~(a_wr & same_addr);

    // A conflict is any same-address pair where at least one side writes.
    // Two reads of the same address are not a conflict.
    assign collision_d = same_addr & ((a_wr & b_wr) | (a_wr & b_rd) | (b_wr & a_rd));

    // Select the read word for each port: old contents, or the other port's write data when bypass is enabled.
    always_comb begin
        a_word = mem[bus.a_addr];
        b_word = mem[bus.b_addr];
`ifdef TDPR_WRITE_THROUGH_EN
        if (b_wr_eff && same_addr) begin
            a_word = bus.b_data_in;
        end
        if (a_wr && same_addr) begin
            b_word = bus.a_data_in;
        end
`endif
    end

    // Memory array update. Contents survive reset, but writes are blocked while reset is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (a_wr) begin
                mem[bus.a_addr] <= bus.a_data_in;
            end
            if (b_wr_eff) begin
                mem[bus.b_addr] <= bus.b_data_in;
            end
        end
    end

    // First read stage and collision flag. Reset clears in-flight reads asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_v1        <= 1'b0;
            b_v1        <= 1'b0;
            a_d1        <= '0;
            b_d1        <= '0;
            collision_q <= 1'b0;
        end else begin
            a_v1        <= a_rd;
            b_v1        <= b_rd;
            a_d1        <= a_rd ? a_word : '0;
            b_d1        <= b_rd ? b_word : '0;
            collision_q <= collision_d;
        end
    end

    assign bus.collision = collision_q;

    if (RD_LATENCY == 2) begin : g_lat2
        logic                  a_v2;
        logic                  b_v2;
        logic [DATA_WIDTH-1:0] a_d2;
        logic [DATA_WIDTH-1:0] b_d2;

        // Extra output stage. Data is already zero in idle slots, so it moves through unchanged.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_v2 <= 1'b0;
                b_v2 <= 1'b0;
                a_d2 <= '0;
                b_d2 <= '0;
            end else begin
                a_v2 <= a_v1;
                b_v2 <= b_v1;
                a_d2 <= a_d1;
                b_d2 <= b_d1;
            end
        end

        assign bus.a_rd_valid = a_v2;
        assign bus.b_rd_valid = b_v2;
        assign bus.a_data_out = a_d2;
        assign bus.b_data_out = b_d2;
    end else begin : g_lat1
        assign bus.a_rd_valid = a_v1;
        assign bus.b_rd_valid = b_v1;
        assign bus.a_data_out = a_d1;
        assign bus.b_data_out = b_d1;
    end
endmodule

// File: tb/tb_true_dual_port_ram.sv
// Bench for true_dual_port_ram. It drives two instances with the same
// stimulus: u_lat1 has RD_LATENCY=1 and u_lat2 has RD_LATENCY=2.
// Each expected read is queued together with the edge on which it must
// appear. A monitor pops and compares the queue whenever rd_valid is seen.
module tb_true_dual_port_ram;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int W  = 16 + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edge_n = 0;
    int   total = 0;
    int   bad = 0;

    // Queues 0:lat1 port A, 1:lat1 port B, 2:lat2 port A, 3:lat2 port B.
    // Each entry is {due_edge[15:0], data}.
    logic [W-1:0]  exp_q [4][$];
    // Edges on which collision must be high: 0 for lat1, 1 for lat2.
    logic [15:0]   coll_q [2][$];

    true_dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();
    true_dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if2 ();

    true_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_lat1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    true_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2)) u_lat2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // ---------------- driver tasks ----------------
    task automatic set_a(input logic cs, input logic we, input logic oe,
                         input logic [AW-1:0] addr, input logic [DW-1:0] din);
        if1.a_cs = cs; if1.a_we = we; if1.a_oe = oe; if1.a_addr = addr; if1.a_data_in = din;
        if2.a_cs = cs; if2.a_we = we; if2.a_oe = oe; if2.a_addr = addr; if2.a_data_in = din;
    endtask

    task automatic set_b(input logic cs, input logic we, input logic oe,
                         input logic [AW-1:0] addr, input logic [DW-1:0] din);
        if1.b_cs = cs; if1.b_we = we; if1.b_oe = oe; if1.b_addr = addr; if1.b_data_in = din;
        if2.b_cs = cs; if2.b_we = we; if2.b_oe = oe; if2.b_addr = addr; if2.b_data_in = din;
    endtask

    task automatic idle();
        set_a(1'b0, 1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Queue an expected read on port p (0=A, 1=B) for the read issued at the next edge.
    task automatic push_rd(input int p, input logic [DW-1:0] data);
        logic [15:0] issue;
        issue = 16'(edge_n + 1);
        exp_q[p].push_back({issue, data});
        exp_q[2 + p].push_back({16'(issue + 16'd1), data});
    endtask

    task automatic push_coll();
        coll_q[0].push_back(16'(edge_n + 1));
        coll_q[1].push_back(16'(edge_n + 1));
    endtask

    task automatic wr_a(input logic [AW-1:0] addr, input logic [DW-1:0] d); set_a(1'b1, 1'b1, 1'b0, addr, d); endtask
    task automatic wr_b(input logic [AW-1:0] addr, input logic [DW-1:0] d); set_b(1'b1, 1'b1, 1'b0, addr, d); endtask
    task automatic rd_a(input logic [AW-1:0] addr, input logic [DW-1:0] e); set_a(1'b1, 1'b0, 1'b1, addr, '0); push_rd(0, e); endtask
    task automatic rd_b(input logic [AW-1:0] addr, input logic [DW-1:0] e); set_b(1'b1, 1'b0, 1'b1, addr, '0); push_rd(1, e); endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic check_eq(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic check_port(input int idx, input logic vld, input logic [DW-1:0] dout, input string nm);
        logic [W-1:0] e;
        if (vld === 1'b1) begin
            total++;
            if (exp_q[idx].size() == 0) begin
                bad++;
                $display("FAIL %s unexpected rd_valid edge=%0d data=%h", nm, edge_n, dout);
            end else begin
                e = exp_q[idx].pop_front();
                if (e[W-1:DW] !== 16'(edge_n) || e[DW-1:0] !== dout) begin
                    bad++;
                    $display("FAIL %s actual edge=%0d data=%h expected edge=%0d data=%h",
                             nm, edge_n, dout, e[W-1:DW], e[DW-1:0]);
                end
            end
        end else begin
            total++;
            if (vld !== 1'b0 || dout !== '0) begin
                bad++;
                $display("FAIL %s idle output actual valid=%b data=%h expected valid=0 data=00", nm, vld, dout);
            end
            if (exp_q[idx].size() != 0 && exp_q[idx][0][W-1:DW] <= 16'(edge_n)) begin
                e = exp_q[idx].pop_front();
                total++;
                bad++;
                $display("FAIL %s missing read actual valid=0 expected edge=%0d data=%h", nm, e[W-1:DW], e[DW-1:0]);
            end
        end
    endtask

    task automatic check_coll(input int idx, input logic c, input string nm);
        logic [15:0] e;
        if (c === 1'b1) begin
            total++;
            if (coll_q[idx].size() == 0 || coll_q[idx][0] != 16'(edge_n)) begin
                bad++;
                $display("FAIL %s unexpected collision actual=1 expected=0 edge=%0d", nm, edge_n);
            end else begin
                e = coll_q[idx].pop_front();
            end
        end else if (coll_q[idx].size() != 0 && coll_q[idx][0] <= 16'(edge_n)) begin
            e = coll_q[idx].pop_front();
            total++;
            bad++;
            $display("FAIL %s missing collision actual=%b expected=1 edge=%0d", nm, c, e);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        check_port(0, if1.a_rd_valid, if1.a_data_out, "lat1_a");
        check_port(1, if1.b_rd_valid, if1.b_data_out, "lat1_b");
        check_port(2, if2.a_rd_valid, if2.a_data_out, "lat2_a");
        check_port(3, if2.b_rd_valid, if2.b_data_out, "lat2_b");
        check_coll(0, if1.collision, "lat1_coll");
        check_coll(1, if2.collision, "lat2_coll");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        idle();
        repeat (3) @(negedge clk);
        check_eq("reset_lat1_coll", {7'd0, if1.collision}, 8'h00);
        check_eq("reset_lat2_a_dout", if2.a_data_out, 8'h00);
        rst = 1'b0;

        // A writes addr 3, then B reads it back.
        wr_a(4'd3, 8'h5A); tick();
        rd_b(4'd3, 8'h5A); tick();

        // Writes on both ports to different addresses in the same cycle.
        wr_a(4'd0, 8'h11); wr_b(4'd5, 8'h01); tick();
        wr_a(4'd1, 8'h22); wr_b(4'd9, 8'h99); tick();
        wr_a(4'd2, 8'h33); wr_b(4'd6, 8'h60); tick();

        // Back-to-back reads on both ports, with no bubbles between results.
        rd_a(4'd0, 8'h11); rd_b(4'd5, 8'h01); tick();
        rd_a(4'd1, 8'h22); rd_b(4'd9, 8'h99); tick();
        rd_a(4'd2, 8'h33); rd_b(4'd3, 8'h5A); tick();

        // Both ports write addr 7 in the same cycle: A wins and collision is flagged.
        wr_a(4'd7, 8'hAA); wr_b(4'd7, 8'hBB); push_coll(); tick();
        // Two reads of the same address: no collision.
        rd_a(4'd7, 8'hAA); rd_b(4'd7, 8'hAA); tick();

        // Cross-port write and read of the same address in the same cycle.
`ifdef TDPR_WRITE_THROUGH_EN
        wr_a(4'd5, 8'h02); rd_b(4'd5, 8'h02); push_coll(); tick();
        wr_b(4'd6, 8'h66); rd_a(4'd6, 8'h66); push_coll(); tick();
`else
        wr_a(4'd5, 8'h02); rd_b(4'd5, 8'h01); push_coll(); tick();
        wr_b(4'd6, 8'h66); rd_a(4'd6, 8'h60); push_coll(); tick();
`endif
        rd_b(4'd5, 8'h02); rd_a(4'd6, 8'h66); tick();

        // A read with oe=0 must not be issued.
        wr_a(4'd2, 8'h44); tick();
        set_a(1'b1, 1'b0, 1'b0, 4'd2, 8'h00); tick();

        // Highest and lowest addresses.
        wr_a(4'd15, 8'hF0); wr_b(4'd0, 8'h0F); tick();
        wr_a(4'd4, 8'hE4); tick();
        rd_a(4'd15, 8'hF0); tick();
        rd_a(4'd0, 8'h0F); tick();

        // Asynchronous reset while a read is still in flight.
        rd_a(4'd15, 8'hF0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_lat1_a_valid", {7'd0, if1.a_rd_valid}, 8'h00);
        check_eq("async_rst_lat1_a_dout", if1.a_data_out, 8'h00);
        check_eq("async_rst_lat2_a_valid", {7'd0, if2.a_rd_valid}, 8'h00);
        check_eq("async_rst_lat2_a_dout", if2.a_data_out, 8'h00);
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        // Try to write while reset is high. The write must be blocked.
        @(negedge clk);
        wr_a(4'd4, 8'hE5);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst = 1'b0;

        // Memory survives reset. The blocked write did not land.
        rd_a(4'd15, 8'hF0); rd_b(4'd2, 8'h44); tick();
        rd_a(4'd4, 8'hE4); tick();

        repeat (4) tick();

        for (int i = 0; i < 4; i++) begin
            total++;
            if (exp_q[i].size() != 0) begin
                bad++;
                $display("FAIL drain_q%0d actual=%0d expected=0 entries", i, exp_q[i].size());
            end
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if (coll_q[i].size() != 0) begin
                bad++;
                $display("FAIL drain_coll%0d actual=%0d expected=0 entries", i, coll_q[i].size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog for a hung run.
    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/true_dual_port_ram.md
TRUE_DUAL_PORT_RAM -- requirements
Module: true_dual_port_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each memory word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter RD_LATENCY, default 1: read latency in cycles, legal values 1 or 2; any other value is an elaboration error.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports a_cs, b_cs  input  1  per-port chip select.
REQ-007 SHALL have ports a_we, b_we  input  1  per-port write enable (1 = write, 0 = read).
REQ-008 SHALL have ports a_oe, b_oe  input  1  per-port output enable; a read is issued only when cs=1, we=0, oe=1.
REQ-009 SHALL have ports a_addr, b_addr  input  ADDR_WIDTH  per-port word address.
REQ-010 SHALL have ports a_data_in, b_data_in  input  DATA_WIDTH  per-port write data.
REQ-011 SHALL have ports a_data_out, b_data_out  output  DATA_WIDTH  per-port read data, registered.
REQ-012 SHALL have ports a_rd_valid, b_rd_valid  output  1  high for one cycle when the matching data_out carries read data.
REQ-013 SHALL have port collision  output  1  registered pulse flagging a same-address conflict (REQ-020).

Function
REQ-014 A write SHALL occur when cs=1 and we=1; mem[addr] <= data_in at that edge.
REQ-015 A read issued at edge N SHALL present data on data_out with rd_valid=1 at edge N+RD_LATENCY-1 (RD_LATENCY=1: registered at the issuing edge; RD_LATENCY=2: one extra pipeline stage).
REQ-016 Data_out SHALL be 0 and rd_valid 0 whenever no read result is being presented; data_out is never driven to high-Z.
REQ-017 Back-to-back reads on one port SHALL be accepted every cycle; results emerge in issue order with no bubbles.
REQ-018 Ports A and B SHALL operate fully independently on different addresses in the same cycle.
REQ-019 Cross-port read/write to the same address in the same cycle SHALL return the old word (read-first) unless REQ-026 applies.
REQ-020 Both ports writing the same address in the same cycle: port A data SHALL be stored, port B write dropped, collision=1 on the following cycle.
REQ-021 Collision SHALL also pulse for a cross-port same-address read/write; two reads of the same address SHALL NOT flag collision.
REQ-022 Address wrap: all ADDR_WIDTH-bit addresses are valid; no out-of-range case exists.
REQ-023 Reads with cs=1, we=0, oe=0 SHALL NOT issue; the pipeline for that slot carries rd_valid=0.

Reset
REQ-024 While rst=1: all data_out=0, all rd_valid=0, collision=0, pipeline stages cleared, writes blocked; asserting rst mid-read discards in-flight reads.
REQ-025 Memory contents SHALL NOT be reset; a read after reset returns the last written value (undefined if never written).

Configuration
REQ-026 Macro TDPR_WRITE_THROUGH_EN: when defined, a cross-port read of the address written in the same cycle SHALL return the new write data (write-through bypass) and collision is still flagged; when undefined, read-first per REQ-019.

Verification
REQ-027 Defaults, write A addr 3 = 0x5A, then read B addr 3 -> b_data_out=0x5A, b_rd_valid=1 exactly 1 cycle after the read edge.
REQ-028 RD_LATENCY=2, reads A addr 0,1,2 on consecutive cycles after writes 0x11,0x22,0x33 -> a_data_out 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first read, a_rd_valid high for 3 cycles.
REQ-029 A writes 0xAA, B writes 0xBB to addr 7 same cycle -> collision=1 next cycle; later read addr 7 returns 0xAA.
REQ-030 addr 5 holds 0x01; A writes 0x02 and B reads addr 5 same cycle -> b_data_out=0x01 without macro, 0x02 with TDPR_WRITE_THROUGH_EN; collision=1 in both builds.
REQ-031 Issue read on A, assert rst asynchronously before data returns -> a_rd_valid=0, a_data_out=0 immediately; after release, addr content still readable unchanged.
REQ-032 Read with oe=0 on addr 2 (holds 0x44) -> rd_valid stays 0, data_out stays 0.
